// File: rtl/darkriscv_resp_pkg.sv
// Shared types for the darkriscv bus responder: data FSM states, DLEN encodings and
// lane-select / alignment helper.
package darkriscv_resp_pkg;

  typedef enum logic [1:0] {StIdle, StWait, StResp} resp_state_e;

  localparam logic [2:0] DlenByte = 3'b001;
  localparam logic [2:0] DlenHalf = 3'b010;
  localparam logic [2:0] DlenWord = 3'b100;

  typedef struct packed {
    logic [3:0] be;
    logic       bad;
  } lane_sel_t;

  // Byte enables for an access; a misaligned or non-one-hot access enables no lanes.
  function automatic lane_sel_t lane_sel(input logic [2:0] dlen, input logic [1:0] off);
    lane_sel_t s;
    s.be  = 4'b0000;
    s.bad = 1'b0;
    case (dlen)
      DlenByte: s.be = 4'b0001 << off;
      DlenHalf: begin
        s.be  = off[1] ? 4'b1100 : 4'b0011;
        s.bad = off[0];
      end
      DlenWord: begin
        s.be  = 4'b1111;
        s.bad = (off != 2'b00);
      end
      default: s.bad = 1'b1;
    endcase
    if (s.bad) s.be = 4'b0000;
    return s;
  endfunction

endpackage

// File: rtl/darkriscv_resp_ram.sv
// Byte-enabled RAM: one write port, registered read port. Contents are never reset,
// only the read register is.
module darkriscv_resp_ram #(
  parameter int unsigned DEPTH = 256,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RES,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) rdata <= '0;
    else      rdata <= mem[raddr];
  end

endmodule

// File: rtl/darkriscv_bus_responder.sv
// Instruction/data memory responder for the darkriscv core with wait states and error flag.
// Optional periodic IRQ enabled by defining DARKRISCV_RESP_IRQ_EN.
module darkriscv_bus_responder
  import darkriscv_resp_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH  = 256,
  parameter int unsigned DMEM_DEPTH  = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned IRQ_PERIOD  = 1000
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic [31:0] IADDR,
  output logic [31:0] IDATA,
  input  logic [31:0] DADDR,
  input  logic [31:0] DATAO,
  output logic [31:0] DATAI,
  input  logic [2:0]  DLEN,
  input  logic        DRD,
  input  logic        DWR,
  output logic        HLT,
  output logic        IRQ,
  input  logic        LDEN,
  input  logic [31:0] LDADDR,
  input  logic [31:0] LDDATA,
  output logic        ERR
);

  localparam int unsigned IAW = $clog2(IMEM_DEPTH);
  localparam int unsigned DAW = $clog2(DMEM_DEPTH);
  localparam logic [3:0] WaitLast = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  darkriscv_resp_ram #(.DEPTH(IMEM_DEPTH)) u_imem (
    .CLK   (CLK),
    .RES   (RES),
    .we    ({4{LDEN}}),
    .waddr (LDADDR[IAW+1:2]),
    .wdata (LDDATA),
    .raddr (IADDR[IAW+1:2]),
    .rdata (IDATA)
  );

  resp_state_e    state_q, state_d;
  logic [3:0]     wcnt_q, wcnt_d;
  logic [DAW-1:0] idx_q;
  logic [1:0]     off_q;
  logic [2:0]     len_q;
  logic           wr_q, bad_q;
  logic [3:0]     be_q;
  logic [31:0]    wdata_q, datai_q;
  logic           err_q;
  logic           start;
  lane_sel_t      sel;
  logic [31:0]    wdata_rep, dmem_rdata, shifted, rd_ext, resp_data;

  assign start = DRD | DWR;
  assign sel   = lane_sel(DLEN, DADDR[1:0]);

  // Replicate the right-aligned write data so byte enables pick the right lanes.
  always_comb begin
    wdata_rep = DATAO;
    if (DLEN == DlenByte)      wdata_rep = {4{DATAO[7:0]}};
    else if (DLEN == DlenHalf) wdata_rep = {2{DATAO[15:0]}};
  end

  darkriscv_resp_ram #(.DEPTH(DMEM_DEPTH)) u_dmem (
    .CLK   (CLK),
    .RES   (RES),
    .we    ((state_q == StResp && wr_q) ? be_q : 4'b0000),
    .waddr (idx_q),
    .wdata (wdata_q),
    .raddr ((state_q == StIdle) ? DADDR[DAW+1:2] : idx_q),
    .rdata (dmem_rdata)
  );

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_q <= StIdle;
      wcnt_q  <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      len_q   <= '0;
      wr_q    <= 1'b0;
      bad_q   <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      datai_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (state_q == StIdle && start) begin
        idx_q   <= DADDR[DAW+1:2];
        off_q   <= DADDR[1:0];
        len_q   <= DLEN;
        wr_q    <= DWR;
        bad_q   <= sel.bad;
        be_q    <= sel.be;
        wdata_q <= wdata_rep;
        err_q   <= err_q | sel.bad | (DRD & DWR);
      end
      if (state_q == StResp) datai_q <= resp_data;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (WAIT_STATES == 0) ? StResp : StWait;
          wcnt_d  = '0;
        end
      end
      StWait: begin
        if (wcnt_q == WaitLast) state_d = StResp;
        else                    wcnt_d  = wcnt_q + 4'd1;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    shifted = dmem_rdata >> {off_q, 3'b000};
    case (len_q)
      DlenByte: rd_ext = {24'b0, shifted[7:0]};
      DlenHalf: rd_ext = {16'b0, shifted[15:0]};
      default:  rd_ext = shifted;
    endcase
    // Writes leave the last read value in place; bad accesses return zero.
    resp_data = bad_q ? 32'b0 : (wr_q ? datai_q : rd_ext);
    DATAI     = (state_q == StResp) ? resp_data : datai_q;
    HLT       = (state_q == StWait);
    ERR       = err_q;
  end

  logic unused_bits;

`ifdef DARKRISCV_RESP_IRQ_EN
  localparam int unsigned IrqW = (IRQ_PERIOD > 1) ? $clog2(IRQ_PERIOD) : 1;
  logic [IrqW-1:0] irq_cnt_q;
  logic            irq_q;

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      irq_cnt_q <= '0;
      irq_q     <= 1'b0;
    end else if (IRQ_PERIOD == 0) begin
      irq_q <= 1'b0;
    end else if (irq_cnt_q == IrqW'(IRQ_PERIOD - 1)) begin
      irq_cnt_q <= '0;
      irq_q     <= 1'b1;
    end else begin
      irq_cnt_q <= irq_cnt_q + 1'b1;
      irq_q     <= 1'b0;
    end
  end

  assign IRQ = irq_q;
  assign unused_bits = ^{IADDR[31:IAW+2], IADDR[1:0], LDADDR[31:IAW+2], LDADDR[1:0],
                         DADDR[31:DAW+2]};
`else
  assign IRQ = 1'b0;
  assign unused_bits = ^{IADDR[31:IAW+2], IADDR[1:0], LDADDR[31:IAW+2], LDADDR[1:0],
                         DADDR[31:DAW+2], 32'(IRQ_PERIOD)};
`endif

endmodule

// File: tb/tb_darkriscv_bus_responder.sv
// Self-checking bench for darkriscv_bus_responder: vector table, hand sequences and
// randomized traffic against a byte-array memory model.
module tb_darkriscv_bus_responder;

  localparam int unsigned WS   = 3;
  localparam int unsigned IRQP = 10;
  localparam int unsigned DD   = 256;
  localparam int unsigned ID   = 256;

  logic        CLK = 1'b0;
  logic        RES = 1'b0;
  logic [31:0] IADDR = '0, DADDR = '0, DATAO = '0, LDADDR = '0, LDDATA = '0;
  logic [31:0] IDATA, DATAI;
  logic [2:0]  DLEN = 3'b100;
  logic        DRD = 1'b0, DWR = 1'b0, LDEN = 1'b0;
  logic        HLT, IRQ, ERR;

  always #5 CLK = ~CLK;

  darkriscv_bus_responder #(
    .IMEM_DEPTH  (ID),
    .DMEM_DEPTH  (DD),
    .WAIT_STATES (WS),
    .IRQ_PERIOD  (IRQP)
  ) dut (
    .CLK    (CLK),
    .RES    (RES),
    .IADDR  (IADDR),
    .IDATA  (IDATA),
    .DADDR  (DADDR),
    .DATAO  (DATAO),
    .DATAI  (DATAI),
    .DLEN   (DLEN),
    .DRD    (DRD),
    .DWR    (DWR),
    .HLT    (HLT),
    .IRQ    (IRQ),
    .LDEN   (LDEN),
    .LDADDR (LDADDR),
    .LDDATA (LDDATA),
    .ERR    (ERR)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]  dm [DD*4];
  logic [31:0] im [ID];
  logic        err_m = 1'b0;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [2:0]  len;
    logic [31:0] addr;
    logic [31:0] data;
    logic        chk;
    logic [31:0] exp;
    logic        exp_err;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic model_bad(input logic [2:0] len, input logic [1:0] off);
    return ($countones(len) != 1) || (len == 3'b010 && off[0]) || (len == 3'b100 && off != 0);
  endfunction

  function automatic int nbytes(input logic [2:0] len);
    return (len == 3'b001) ? 1 : (len == 3'b010) ? 2 : 4;
  endfunction

  // Memory as bytes: base of the wrapped word plus the byte offset.
  task automatic model_access(input logic wr, input logic rd, input logic [2:0] len,
                              input logic [31:0] addr, input logic [31:0] data,
                              output logic [31:0] exp);
    logic bad;
    int   base;
    bad   = model_bad(len, addr[1:0]);
    base  = int'(addr[9:2]) * 4 + int'(addr[1:0]);
    err_m = err_m | bad | (wr & rd);
    exp   = '0;
    if (!bad) begin
      for (int i = 0; i < nbytes(len); i++) begin
        if (wr) dm[base + i] = data[8*i +: 8];
        else if (rd) exp[8*i +: 8] = dm[base + i];
      end
    end
  endtask

  task automatic access(input logic wr, input logic rd, input logic [2:0] len,
                        input logic [31:0] addr, input logic [31:0] data,
                        output logic [31:0] rdata, output logic [31:0] held,
                        output int hcnt, output logic err);
    @(negedge CLK);
    DWR = wr; DRD = rd; DLEN = len; DADDR = addr; DATAO = data;
    @(negedge CLK);
    DWR = 1'b0; DRD = 1'b0;
    hcnt = 0;
    while (HLT && hcnt < 40) begin
      hcnt++;
      @(negedge CLK);
    end
    rdata = DATAI;
    err   = ERR;
    @(posedge CLK);
    #1 held = DATAI;
  endtask

  task automatic run_check(input string name, input logic wr, input logic rd,
                           input logic [2:0] len, input logic [31:0] addr,
                           input logic [31:0] data);
    logic [31:0] rdata, held, exp;
    int          hcnt;
    logic        err;
    access(wr, rd, len, addr, data, rdata, held, hcnt, err);
    model_access(wr, rd, len, addr, data, exp);
    check({name, "_hlt"}, hcnt, WS);
    check({name, "_err"}, {31'b0, err}, {31'b0, err_m});
    if ((rd && !wr) || model_bad(len, addr[1:0])) begin
      check({name, "_datai"}, rdata, exp);
      check({name, "_hold"}, held, exp);
    end
  endtask

  task automatic check_irq_window();
    logic exp;
    for (int n = 1; n <= 25; n++) begin
      @(posedge CLK);
      #1;
`ifdef DARKRISCV_RESP_IRQ_EN
      exp = (n % IRQP == 0);
`else
      exp = 1'b0;
`endif
      check($sformatf("irq_cycle%0d", n), {31'b0, IRQ}, {31'b0, exp});
    end
  endtask

  initial begin
    logic [31:0] rdata, held, exp, tmp, old;
    int          hcnt;
    logic        err, wr, rd;
    logic [2:0]  len;
    logic [31:0] addr;
    int          r, idx;

    tbl[0]  = '{1, 0, 3'b100, 32'h20,  32'hDEADBEEF, 0, 32'h0,        0};
    tbl[1]  = '{0, 1, 3'b001, 32'h21,  32'h0,        1, 32'h000000BE, 0};
    tbl[2]  = '{1, 0, 3'b100, 32'h20,  32'h11223344, 0, 32'h0,        0};
    tbl[3]  = '{1, 0, 3'b010, 32'h22,  32'h1234AAAA, 0, 32'h0,        0};
    tbl[4]  = '{0, 1, 3'b100, 32'h20,  32'h0,        1, 32'hAAAA3344, 0};
    tbl[5]  = '{1, 0, 3'b100, 32'h400, 32'hCAFEF00D, 0, 32'h0,        0};
    tbl[6]  = '{0, 1, 3'b100, 32'h000, 32'h0,        1, 32'hCAFEF00D, 0};
    tbl[7]  = '{0, 1, 3'b010, 32'h22,  32'h0,        1, 32'h0000AAAA, 0};
    tbl[8]  = '{0, 1, 3'b001, 32'h23,  32'h0,        1, 32'h000000AA, 0};
    tbl[9]  = '{0, 1, 3'b100, 32'h02,  32'h0,        1, 32'h0,        1};
    tbl[10] = '{0, 1, 3'b100, 32'h20,  32'h0,        1, 32'hAAAA3344, 1};

    repeat (3) @(posedge CLK);
    #1;
    check("rst_idata", IDATA, 32'h0);
    check("rst_datai", DATAI, 32'h0);
    check("rst_hlt", {31'b0, HLT}, 32'h0);
    check("rst_irq", {31'b0, IRQ}, 32'h0);
    check("rst_err", {31'b0, ERR}, 32'h0);
    @(negedge CLK);
    RES = 1'b1;

    // Instruction memory: preload, fetch, same-cycle load, random traffic.
    for (int i = 0; i < int'(ID); i++) begin
      @(negedge CLK);
      LDEN = 1'b1; LDADDR = i * 4; LDDATA = (i == 4) ? 32'h00000013 : $urandom;
      im[i] = LDDATA;
    end
    @(negedge CLK);
    LDEN = 1'b0; IADDR = 32'h10;
    @(posedge CLK);
    #1 check("ifetch_0x10", IDATA, 32'h00000013);
    @(negedge CLK);
    LDEN = 1'b1; LDADDR = 32'h14; LDDATA = 32'hCAFE0001; IADDR = 32'h14;
    old = im[5];
    @(posedge CLK);
    #1 check("ifetch_same_cycle_old", IDATA, old);
    im[5] = 32'hCAFE0001;
    @(negedge CLK);
    LDEN = 1'b0;
    @(posedge CLK);
    #1 check("ifetch_after_load", IDATA, 32'hCAFE0001);
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      LDEN = $urandom_range(0, 1); LDADDR = $urandom; LDDATA = $urandom; IADDR = $urandom;
      exp = im[IADDR[9:2]];
      @(posedge CLK);
      #1 check($sformatf("ifetch_rand%0d", i), IDATA, exp);
      if (LDEN) im[LDADDR[9:2]] = LDDATA;
    end
    @(negedge CLK);
    LDEN = 1'b0;

    for (int i = 0; i < 11; i++) begin
      access(tbl[i].wr, tbl[i].rd, tbl[i].len, tbl[i].addr, tbl[i].data, rdata, held, hcnt, err);
      model_access(tbl[i].wr, tbl[i].rd, tbl[i].len, tbl[i].addr, tbl[i].data, tmp);
      check($sformatf("vec%0d_hlt", i), hcnt, WS);
      check($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, tbl[i].exp_err});
      if (tbl[i].chk) begin
        check($sformatf("vec%0d_datai", i), rdata, tbl[i].exp);
        check($sformatf("vec%0d_hold", i), held, tbl[i].exp);
      end
    end

    for (int w = 0; w < int'(DD); w++) begin
      tmp = $urandom;
      access(1'b1, 1'b0, 3'b100, w * 4, tmp, rdata, held, hcnt, err);
      model_access(1'b1, 1'b0, 3'b100, w * 4, tmp, exp);
    end

    for (int i = 0; i < 150; i++) begin
      wr = $urandom_range(0, 1);
      rd = !wr;
      if ($urandom_range(0, 15) == 0) begin wr = 1'b1; rd = 1'b1; end
      r = $urandom_range(0, 7);
      len = (r < 3) ? 3'b001 : (r < 5) ? 3'b010 : (r < 7) ? 3'b100 : 3'($urandom);
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (len == 3'b100) addr[1:0] = 2'b00;
        else if (len == 3'b010) addr[0] = 1'b0;
      end
      run_check($sformatf("rand%0d", i), wr, rd, len, addr, $urandom);
    end

    // Reset in the middle of a write's wait states discards the write.
    @(negedge CLK);
    DWR = 1'b1; DLEN = 3'b100; DADDR = 32'h40; DATAO = 32'h0BADF00D;
    @(negedge CLK);
    DWR = 1'b0;
    check("mid_wait_hlt", {31'b0, HLT}, 32'h1);
    #2 RES = 1'b0;
    #1;
    check("async_rst_hlt", {31'b0, HLT}, 32'h0);
    check("async_rst_datai", DATAI, 32'h0);
    check("async_rst_err", {31'b0, ERR}, 32'h0);
    check("async_rst_idata", IDATA, 32'h0);
    check("async_rst_irq", {31'b0, IRQ}, 32'h0);
    err_m = 1'b0;
    @(negedge CLK);
    RES = 1'b1;
    check_irq_window();
    run_check("discarded_write", 1'b0, 1'b1, 3'b100, 32'h40, 32'h0);

    run_check("rd_wr_both", 1'b1, 1'b1, 3'b100, 32'h80, 32'h5A5A1234);
    run_check("rd_wr_result", 1'b0, 1'b1, 3'b100, 32'h80, 32'h0);

    @(negedge CLK);
    RES = 1'b0;
    @(negedge CLK);
    RES = 1'b1;
    err_m = 1'b0;
    run_check("dlen_not_onehot", 1'b1, 1'b0, 3'b011, 32'h84, 32'hFFFFFFFF);
    run_check("dlen_no_write", 1'b0, 1'b1, 3'b100, 32'h84, 32'h0);
    run_check("half_misaligned_rd", 1'b0, 1'b1, 3'b010, 32'h85, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
